// File: rtl/loop_over_all_nibbles_if.sv
// ---------------------------------------------------------------------------
// loop_over_all_nibbles_if
//
// Bundles the command/operand request and the result/status response of the
// nibble-serial ALU so that the core and its user share one port object.
//
// Signals:
//   start      master->slave  single-cycle pulse that begins a word operation
//   cmd        master->slave  3-bit operation code (ADD..PASS)
//   word1      master->slave  32-bit operand A
//   word2      master->slave  32-bit operand B / shift and pass source
//   is_latest  slave->master  high while the final nibble is being processed
//   done       slave->master  high once the word result is complete
//   carry_out  slave->master  final carry/link bit, valid while done is high
//   result     slave->master  32-bit registered result
//
// Modports:
//   master  drives the request side (testbench or surrounding logic)
//   slave   the ALU core itself
// ---------------------------------------------------------------------------
interface loop_over_all_nibbles_if;
  logic        start;
  logic [2:0]  cmd;
  logic [31:0] word1;
  logic [31:0] word2;
  logic        is_latest;
  logic        done;
  logic        carry_out;
  logic [31:0] result;

  modport master (
    output start,
    output cmd,
    output word1,
    output word2,
    input  is_latest,
    input  done,
    input  carry_out,
    input  result
  );

  modport slave (
    input  start,
    input  cmd,
    input  word1,
    input  word2,
    output is_latest,
    output done,
    output carry_out,
    output result
  );
endinterface

// File: rtl/loop_over_all_nibbles.sv
// ---------------------------------------------------------------------------
// loop_over_all_nibbles
//
// Nibble-serial 32-bit ALU. A start pulse latches the command and both
// operands; the core then walks the eight nibbles of the word, one per
// clock, through a 4-bit ALU whose carry/link bit is registered between
// nibbles. Each processed nibble is written back into the result register.
// Shift-right walks from the top nibble down so the link bit carries the
// bit shifted out of the nibble above; all other commands walk upwards.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset, takes priority over start
//   bus   slave modport of loop_over_all_nibbles_if
//           start/cmd/word1/word2 in, is_latest/done/carry_out/result out
//
// Parameters:
//   CNT_SIZE  width of the nibble index; only 3 (8 nibbles) is supported
// ---------------------------------------------------------------------------
module loop_over_all_nibbles #(
  parameter int CNT_SIZE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  loop_over_all_nibbles_if.slave   bus
);

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_SUB   = 3'd1,
    CMD_AND   = 3'd2,
    CMD_OR    = 3'd3,
    CMD_XOR   = 3'd4,
    CMD_RSHFT = 3'd5,
    CMD_LSHFT = 3'd6,
    CMD_PASS  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [CNT_SIZE-1:0] FIRST_IDX = '0;
  localparam logic [CNT_SIZE-1:0] LAST_IDX  = '1;

  state_e              state_q, state_d;
  cmd_e                cmd_q, cmd_d;
  logic [31:0]         word1_q, word1_d;
  logic [31:0]         word2_q, word2_d;
  logic [31:0]         result_q, result_d;
  logic [CNT_SIZE-1:0] idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                reverse_q, reverse_d;

  logic                busy;
  logic                isLatest;
  logic [3:0]          d1;
  logic [3:0]          d2;
  logic [3:0]          nibbleR;
  logic                carryNext;
  logic [4:0]          sum5;

  assign busy     = (state_q == S_BUSY);
  assign isLatest = busy && (idx_q == (reverse_q ? FIRST_IDX : LAST_IDX));

  assign d1 = word1_q[{idx_q, 2'b00} +: 4];
  assign d2 = word2_q[{idx_q, 2'b00} +: 4];

  // Nibble ALU. Subtraction is done as d1 + ~d2 + carry, with the carry
  // seeded to 1 at start, so a final carry of 1 means "no borrow". The
  // shifts use the carry as the link bit entering from the neighbouring
  // nibble and export the bit that falls off the other end.
  always_comb begin
    sum5      = 5'd0;
    nibbleR   = 4'd0;
    carryNext = 1'b0;
    case (cmd_q)
      CMD_ADD: begin
        sum5 = {1'b0, d1} + {1'b0, d2} + {4'b0000, carry_q};
        {carryNext, nibbleR} = sum5;
      end
      CMD_SUB: begin
        sum5 = {1'b0, d1} + {1'b0, ~d2} + {4'b0000, carry_q};
        {carryNext, nibbleR} = sum5;
      end
      CMD_AND:   nibbleR = d1 & d2;
      CMD_OR:    nibbleR = d1 | d2;
      CMD_XOR:   nibbleR = d1 ^ d2;
      CMD_RSHFT: begin
        nibbleR   = {carry_q, d2[3:1]};
        carryNext = d2[0];
      end
      CMD_LSHFT: begin
        nibbleR   = {d2[2:0], carry_q};
        carryNext = d2[3];
      end
      CMD_PASS:  nibbleR = d2;
      default:   nibbleR = 4'd0;
    endcase
  end

  // Control FSM next state: start (re)launches from any state, the final
  // nibble moves to DONE, and DONE is held until the next start.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = S_BUSY;
    end else if (isLatest) begin
      state_d = S_DONE;
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next state. A start latches everything and clears the result;
  // otherwise each busy cycle overwrites one result nibble and steps the
  // index, except on the final nibble where the index parks in place.
  always_comb begin
    cmd_d     = cmd_q;
    word1_d   = word1_q;
    word2_d   = word2_q;
    result_d  = result_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    reverse_d = reverse_q;
    if (bus.start) begin
      cmd_d     = cmd_e'(bus.cmd);
      word1_d   = bus.word1;
      word2_d   = bus.word2;
      result_d  = 32'd0;
      carry_d   = (cmd_e'(bus.cmd) == CMD_SUB);
      reverse_d = (cmd_e'(bus.cmd) == CMD_RSHFT);
      idx_d     = (cmd_e'(bus.cmd) == CMD_RSHFT) ? LAST_IDX : FIRST_IDX;
    end else if (busy) begin
      result_d[{idx_q, 2'b00} +: 4] = nibbleR;
      carry_d = carryNext;
      if (!isLatest) begin
        idx_d = reverse_q ? (idx_q - CNT_SIZE'(1)) : (idx_q + CNT_SIZE'(1));
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= CMD_ADD;
      word1_q   <= 32'd0;
      word2_q   <= 32'd0;
      result_q  <= 32'd0;
      idx_q     <= FIRST_IDX;
      carry_q   <= 1'b0;
      reverse_q <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      word1_q   <= word1_d;
      word2_q   <= word2_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      reverse_q <= reverse_d;
    end
  end

  assign bus.is_latest = isLatest;
  assign bus.done      = (state_q == S_DONE);
  assign bus.carry_out = carry_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// ---------------------------------------------------------------------------
// tb_loop_over_all_nibbles
//
// Directed bench for the nibble-serial ALU. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled at that same point, well
// away from the next active edge.
// ---------------------------------------------------------------------------
module tb_loop_over_all_nibbles;

  localparam logic [2:0] ADD   = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] AND_C = 3'd2;
  localparam logic [2:0] OR_C  = 3'd3;
  localparam logic [2:0] XOR_C = 3'd4;
  localparam logic [2:0] RSHFT = 3'd5;
  localparam logic [2:0] LSHFT = 3'd6;
  localparam logic [2:0] PASS  = 3'd7;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  loop_over_all_nibbles_if bus();

  loop_over_all_nibbles #(.CNT_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge with the given command/operands, then scramble
  // the operand inputs so any failure to latch them shows up in the result.
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] w1,
                               input logic [31:0] w2);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.word1 = w1;
    bus.word2 = w2;
    tick();
    bus.start = 1'b0;
    bus.cmd   = 3'($urandom_range(0, 7));
    bus.word1 = $urandom;
    bus.word2 = $urandom;
  endtask

  // Full word operation: start edge plus eight processing edges, with
  // is_latest expected only in the cycle before the eighth processing edge.
  task automatic runOp(input string name, input logic [2:0] c,
                       input logic [31:0] w1, input logic [31:0] w2,
                       input logic [31:0] expResult, input logic expCarry);
    applyStimulus(c, w1, w2);
    checkOutput({name, " result_cleared"}, bus.result, 32'd0);
    for (int k = 0; k < 8; k++) begin
      checkOutput({name, " is_latest"}, {31'd0, bus.is_latest}, {31'd0, (k == 7)});
      checkOutput({name, " done_early"}, {31'd0, bus.done}, 32'd0);
      tick();
    end
    checkOutput({name, " result"}, bus.result, expResult);
    checkOutput({name, " carry_out"}, {31'd0, bus.carry_out}, {31'd0, expCarry});
    checkOutput({name, " done"}, {31'd0, bus.done}, 32'd1);
    checkOutput({name, " is_latest_after"}, {31'd0, bus.is_latest}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.cmd   = 3'd0;
    bus.word1 = 32'd0;
    bus.word2 = 32'd0;
    tick();
    tick();

    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset carry_out", {31'd0, bus.carry_out}, 32'd0);
    checkOutput("reset is_latest", {31'd0, bus.is_latest}, 32'd0);
    rst = 1'b0;
    tick();

    runOp("add_carry_chain", ADD, 32'hEFFF_FFFF, 32'h0000_0001, 32'hF000_0000, 1'b0);

    // Idle after completion: everything holds.
    tick();
    tick();
    tick();
    checkOutput("idle result", bus.result, 32'hF000_0000);
    checkOutput("idle done", {31'd0, bus.done}, 32'd1);

    runOp("add_mid", ADD, 32'hFFFF_0FFF, 32'h0000_0002, 32'hFFFF_1001, 1'b0);
    runOp("add_wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    runOp("sub_simple", SUB, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b1);
    runOp("sub_borrow", SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    runOp("lshft", LSHFT, 32'h1234_5678, 32'h8000_0001, 32'h0000_0002, 1'b1);
    runOp("xor", XOR_C, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0);
    runOp("and", AND_C, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0);
    runOp("or", OR_C, 32'h1234_5678, 32'h8080_8080, 32'h92B4_D6F8, 1'b0);
    runOp("pass", PASS, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    // Shift right walks from the top nibble: after two processing edges the
    // top two result nibbles (0 and 3) are already written.
    applyStimulus(RSHFT, $urandom, 32'h0600_0000);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        checkOutput("rshft partial", bus.result, 32'h0300_0000);
      end
      checkOutput("rshft is_latest", {31'd0, bus.is_latest}, {31'd0, (k == 7)});
      tick();
    end
    checkOutput("rshft result", bus.result, 32'h0300_0000);
    checkOutput("rshft carry_out", {31'd0, bus.carry_out}, 32'd0);
    checkOutput("rshft done", {31'd0, bus.done}, 32'd1);

    // Restart: an ADD is aborted on its fourth edge by a new RSHFT.
    applyStimulus(ADD, 32'h1111_1111, 32'h2222_2222);
    tick();
    tick();
    runOp("restart_rshft", RSHFT, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_0007, 1'b1);

    // Reset in the middle of an operation.
    applyStimulus(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst result", bus.result, 32'd0);
    checkOutput("midrst done", {31'd0, bus.done}, 32'd0);
    checkOutput("midrst carry_out", {31'd0, bus.carry_out}, 32'd0);
    checkOutput("midrst is_latest", {31'd0, bus.is_latest}, 32'd0);
    rst = 1'b0;

    // Reset wins over a simultaneous start: the core stays idle afterwards.
    bus.start = 1'b1;
    bus.cmd   = ADD;
    bus.word1 = 32'h0000_0005;
    bus.word2 = 32'h0000_0003;
    rst       = 1'b1;
    tick();
    bus.start = 1'b0;
    rst       = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
    end
    checkOutput("rst_prio done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_prio result", bus.result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
